// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_access_seq_if.sv
// Command, register-file and result signals of the access sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake on the command side.
// master = sequencer (owns the rf_* selects/strobe), slave = decode/regfile side.
interface regfile_access_seq_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    // command
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_rs1;
    logic [ADDR_WIDTH-1:0] cmd_rs2;
    logic [ADDR_WIDTH-1:0] cmd_rd;
    logic [1:0]            cmd_op;
    logic                  cmd_wen;

    // register file
    logic [ADDR_WIDTH-1:0] rf_seto1;
    logic [ADDR_WIDTH-1:0] rf_seto2;
    logic [DATA_WIDTH-1:0] rf_output1;
    logic [DATA_WIDTH-1:0] rf_output2;
    logic [ADDR_WIDTH-1:0] rf_seti;
    logic [DATA_WIDTH-1:0] rf_input;
    logic                  rf_wr;

    // result / status
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic [ADDR_WIDTH-1:0] res_rd;
    logic [15:0]           done_count;

    modport master (
        input  cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_wen,
        input  rf_output1, rf_output2,
        output cmd_ready,
        output rf_seto1, rf_seto2, rf_seti, rf_input, rf_wr,
        output res_valid, res_data, res_rd, done_count
    );

    modport slave (
        output cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_wen,
        output rf_output1, rf_output2,
        input  cmd_ready,
        input  rf_seto1, rf_seto2, rf_seti, rf_input, rf_wr,
        input  res_valid, res_data, res_rd, done_count
    );

endinterface

// File: rtl/regfile_alu.sv
// Two-operand ALU: ADD/SUB (modulo 2^DATA_WIDTH), AND, OR.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; op selects function; y result.
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [1:0]            op,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;   // carry out discarded
            OP_SUB:  y = a - b;   // borrow wraps
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/regfile_access_seq.sv
// Register-file access sequencer: read rs1/rs2, compute, write rd, one command at a time.
// Latency: accept at T0, READ T0+1, EXEC T0+2, WRITE T0+3, ready again T0+4.
// Backpressure: cmd_ready low outside IDLE; commands are held off, never dropped.
// Ports: clk, reset (async, active-high); bus = master side of regfile_access_seq_if
// (command handshake, rf read selects/data, rf write port, result strobe, done_count).
module regfile_access_seq
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_access_seq_if.master  bus
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] seto1_q;
    logic [ADDR_WIDTH-1:0] seto2_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [1:0]            op_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] opa_q;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [ADDR_WIDTH-1:0] seti_q;
    logic [ADDR_WIDTH-1:0] res_rd_q;
    logic                  wr_q;
    logic                  res_vld_q;
    logic [15:0]           done_q;
    logic [DATA_WIDTH-1:0] alu_y;

    regfile_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a  (opa_q),
        .b  (opb_q),
        .op (op_q),
        .y  (alu_y)
    );

    // Gated by reset so ready is low while reset is held and high in the
    // very first cycle after release (a register reset to 0 would lag a cycle).
    assign bus.cmd_ready  = (state == IDLE) && !reset;

    assign bus.rf_seto1   = seto1_q;
    assign bus.rf_seto2   = seto2_q;
    assign bus.rf_seti    = seti_q;
    assign bus.rf_input   = result_q;
    assign bus.rf_wr      = wr_q;
    assign bus.res_valid  = res_vld_q;
    assign bus.res_data   = result_q;
    assign bus.res_rd     = res_rd_q;
    assign bus.done_count = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            seto1_q   <= '0;
            seto2_q   <= '0;
            rd_q      <= '0;
            op_q      <= OP_ADD;
            wen_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            seti_q    <= '0;
            res_rd_q  <= '0;
            wr_q      <= 1'b0;
            res_vld_q <= 1'b0;
            done_q    <= '0;
        end else begin
            // write strobe and result strobe are single-cycle pulses
            wr_q      <= 1'b0;
            res_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // read selects come straight from the latched indices
                        seto1_q <= bus.cmd_rs1;
                        seto2_q <= bus.cmd_rs2;
                        rd_q    <= bus.cmd_rd;
                        op_q    <= bus.cmd_op;
                        wen_q   <= bus.cmd_wen;
                        state   <= READ;
                    end
                end
                READ: begin
                    opa_q <= bus.rf_output1;
                    opb_q <= bus.rf_output2;
                    state <= EXEC;
                end
                EXEC: begin
                    // registering the WRITE-cycle outputs here keeps them glitch-free
                    result_q  <= alu_y;
                    seti_q    <= rd_q;
                    res_rd_q  <= rd_q;
                    wr_q      <= wen_q;
                    res_vld_q <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (done_q != 16'hFFFF) begin
                        done_q <= done_q + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed bench: real 8x32 register file behind the sequencer, hand-computed expectations.
module tb_regfile_access_seq;
    import regfile_pkg::*;

    logic clk;
    logic reset;

    regfile_access_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    regfile_access_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 8x32 register file: combinational reads, write on rising edge.
    // The bench preload port is only used while the sequencer is idle.
    logic [31:0] rf [8];
    logic        pre_wr;
    logic [2:0]  pre_sel;
    logic [31:0] pre_dat;

    assign bus.rf_output1 = rf[bus.rf_seto1];
    assign bus.rf_output2 = rf[bus.rf_seto2];

    always @(posedge clk) begin
        if (bus.rf_wr) begin
            rf[bus.rf_seti] <= bus.rf_input;
        end else if (pre_wr) begin
            rf[pre_sel] <= pre_dat;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        logic [31:0] i32;
        i32     = idx;
        pre_sel = i32[2:0];
        pre_dat = v;
        pre_wr  = 1'b1;
        tick();
        pre_wr  = 1'b0;
    endtask

    // Issue one command from IDLE and check every phase of it.
    task automatic run_cmd(input string tag, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic [1:0] op, input logic wen,
                           input logic [31:0] exp_res);
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_rd    = rd;
        bus.cmd_op    = op;
        bus.cmd_wen   = wen;
        bus.cmd_valid = 1'b1;
        tick();                              // accept edge T0 -> READ
        bus.cmd_valid = 1'b0;
        chk({tag, "_read_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
        chk({tag, "_seto1"}, {29'd0, bus.rf_seto1}, {29'd0, rs1});
        chk({tag, "_seto2"}, {29'd0, bus.rf_seto2}, {29'd0, rs2});
        tick();                              // EXEC
        chk({tag, "_exec_wr"}, {31'd0, bus.rf_wr}, 32'd0);
        tick();                              // WRITE
        chk({tag, "_wr"}, {31'd0, bus.rf_wr}, {31'd0, wen});
        chk({tag, "_seti"}, {29'd0, bus.rf_seti}, {29'd0, rd});
        chk({tag, "_rf_input"}, bus.rf_input, exp_res);
        chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd1);
        chk({tag, "_res_data"}, bus.res_data, exp_res);
        chk({tag, "_res_rd"}, {29'd0, bus.res_rd}, {29'd0, rd});
        tick();                              // back in IDLE at T0+4
        chk({tag, "_ready_again"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, "_wr_pulse_end"}, {31'd0, bus.rf_wr}, 32'd0);
        chk({tag, "_res_valid_end"}, {31'd0, bus.res_valid}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_rd    = '0;
        bus.cmd_op    = OP_ADD;
        bus.cmd_wen   = 1'b0;
        pre_wr        = 1'b0;
        pre_sel       = '0;
        pre_dat       = '0;

        // ---- reset values ----
        #1;
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        tick();
        chk("rst_wr", {31'd0, bus.rf_wr}, 32'd0);
        chk("rst_seto1", {29'd0, bus.rf_seto1}, 32'd0);
        chk("rst_seti", {29'd0, bus.rf_seti}, 32'd0);
        chk("rst_input", bus.rf_input, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_done", {16'd0, bus.done_count}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // ---- basic ADD: 5 + 3 -> R3 ----
        preload(1, 32'd5);
        preload(2, 32'd3);
        run_cmd("add", 3'd1, 3'd2, 3'd3, OP_ADD, 1'b1, 32'd8);
        chk("add_r3", rf[3], 32'd8);
        chk("add_done", {16'd0, bus.done_count}, 32'd1);

        // ---- wrap-around ----
        preload(1, 32'hFFFF_FFFF);
        preload(2, 32'd1);
        run_cmd("addwrap", 3'd1, 3'd2, 3'd4, OP_ADD, 1'b1, 32'd0);
        chk("addwrap_r4", rf[4], 32'd0);
        preload(1, 32'd0);
        run_cmd("subwrap", 3'd1, 3'd2, 3'd7, OP_SUB, 1'b1, 32'hFFFF_FFFF);
        chk("subwrap_r7", rf[7], 32'hFFFF_FFFF);
        chk("wrap_done", {16'd0, bus.done_count}, 32'd3);

        // ---- dependent back-to-back, cmd_valid held high ----
        preload(1, 32'd10);
        bus.cmd_rs1   = 3'd1;
        bus.cmd_rs2   = 3'd1;
        bus.cmd_rd    = 3'd1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_wen   = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();                              // accept A -> READ
        chk("b2b_a_read_ready", {31'd0, bus.cmd_ready}, 32'd0);
        tick();                              // EXEC
        chk("b2b_a_exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("b2b_a_exec_done", {16'd0, bus.done_count}, 32'd3);
        tick();                              // WRITE
        chk("b2b_a_write_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("b2b_a_input", bus.rf_input, 32'd20);
        chk("b2b_a_wr", {31'd0, bus.rf_wr}, 32'd1);
        tick();                              // IDLE, valid still high
        chk("b2b_a_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("b2b_a_r1", rf[1], 32'd20);
        chk("b2b_a_done", {16'd0, bus.done_count}, 32'd4);
        tick();                              // accept B -> READ
        chk("b2b_b_read_ready", {31'd0, bus.cmd_ready}, 32'd0);
        tick();                              // EXEC
        tick();                              // WRITE
        chk("b2b_b_input", bus.rf_input, 32'd40);
        bus.cmd_valid = 1'b0;
        tick();                              // IDLE
        chk("b2b_b_r1", rf[1], 32'd40);
        chk("b2b_b_done", {16'd0, bus.done_count}, 32'd5);
        tick();                              // no further acceptance
        chk("b2b_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("b2b_idle_done", {16'd0, bus.done_count}, 32'd5);

        // ---- compute-only AND, rd=R2 must stay 1 ----
        preload(5, 32'h0000_F0F0);
        preload(6, 32'h0000_FF00);
        run_cmd("and_nowen", 3'd5, 3'd6, 3'd2, OP_AND, 1'b0, 32'h0000_F000);
        chk("and_r2_kept", rf[2], 32'd1);
        chk("and_done", {16'd0, bus.done_count}, 32'd6);

        // ---- OR, rs1 == rs2 == rd ----
        run_cmd("or_same", 3'd5, 3'd5, 3'd5, OP_OR, 1'b1, 32'h0000_F0F0);
        chk("or_r5", rf[5], 32'h0000_F0F0);

        // ---- reset during EXEC aborts the command ----
        bus.cmd_rs1   = 3'd1;
        bus.cmd_rs2   = 3'd1;
        bus.cmd_rd    = 3'd3;
        bus.cmd_op    = OP_ADD;
        bus.cmd_wen   = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();                              // accept -> READ
        bus.cmd_valid = 1'b0;
        tick();                              // EXEC
        reset = 1'b1;
        #1;
        chk("abort_wr", {31'd0, bus.rf_wr}, 32'd0);
        chk("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("abort_ready_in_rst", {31'd0, bus.cmd_ready}, 32'd0);
        tick();                              // edge that would have entered WRITE
        chk("abort_wr_held", {31'd0, bus.rf_wr}, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready_rel", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_done_cleared", {16'd0, bus.done_count}, 32'd0);
        tick();
        tick();
        chk("abort_post_wr", {31'd0, bus.rf_wr}, 32'd0);
        chk("abort_post_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("abort_r3_kept", rf[3], 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
